// File: rtl/alu_sync_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_sync_ram                                               |
// | Description : Single-port RAM on a shared tri-state data bus, plus a     |
// |               32-bit combinational ALU for the accumulator CPU datapath. |
// |               Optional flag outputs (zero, carry) are built when the     |
// |               macro ALU_SYNC_RAM_FLAGS_EN is defined.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_sync_ram #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe,
    input  logic [31:0]           A,
    input  logic [31:0]           B,
    input  logic [3:0]            ALU_Sel,
`ifdef ALU_SYNC_RAM_FLAGS_EN
    output logic                  zero,
    output logic                  carry,
`endif
    output logic [31:0]           ALU_Out
);

    localparam int c_IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_rd_en;
    logic [31:0]           w_alu_out;

    // Only the low address bits select a word, so addresses wrap modulo DEPTH.
    assign w_idx = addr[c_IDX_W-1:0];

    generate
        if (ADDR_WIDTH > c_IDX_W) begin : g_addr_upper
            logic w_unused_addr;
            assign w_unused_addr = ^addr[ADDR_WIDTH-1:c_IDX_W];
        end
    endgenerate

    // A write request (we=1) always wins over output enable, and reset
    // keeps the bus released.
    assign w_rd_en = cs_input && oe && !we && !rst;
    assign data    = w_rd_en ? r_mem[w_idx] : {DATA_WIDTH{1'bz}};

    // Capture the bus into memory; reset blocks the write (contents are kept).
    always_ff @(posedge clk) begin
        if (!rst && cs_input && we) begin
            r_mem[w_idx] <= data;
        end
    end

    // Unsigned ALU, every result truncated to 32 bits.
    always_comb begin
        w_alu_out = 32'h0;
        case (ALU_Sel)
            4'b0000: w_alu_out = A + B;
            4'b0001: w_alu_out = A - B;
            4'b0010: w_alu_out = {A[30:0], 1'b0};
            4'b0011: w_alu_out = {1'b0, A[31:1]};
            4'b0100: w_alu_out = {A[30:0], A[31]};
            4'b0101: w_alu_out = {A[0], A[31:1]};
            4'b0110: w_alu_out = A & B;
            4'b0111: w_alu_out = A ^ B;
            4'b1000: w_alu_out = A | B;
            4'b1001: w_alu_out = ~(A | B);
            4'b1010: w_alu_out = ~(A & B);
            4'b1011: w_alu_out = ~(A ^ B);
            4'b1100: w_alu_out = (A > B) ? 32'h1 : 32'h0;
            4'b1101: w_alu_out = (A == B) ? 32'h1 : 32'h0;
            4'b1110: w_alu_out = A;
            4'b1111: w_alu_out = B;
            default: w_alu_out = 32'h0;
        endcase
    end

    assign ALU_Out = w_alu_out;

`ifdef ALU_SYNC_RAM_FLAGS_EN
    logic        w_add_carry;
    logic [31:0] w_unused_sum;

    assign {w_add_carry, w_unused_sum} = {1'b0, A} + {1'b0, B};

    // Carry means carry-out for add, borrow for subtract, and the bit shifted
    // out for the plain shifts; it is zero for everything else.
    always_comb begin
        carry = 1'b0;
        case (ALU_Sel)
            4'b0000: carry = w_add_carry;
            4'b0001: carry = (A < B);
            4'b0010: carry = A[31];
            4'b0011: carry = A[0];
            default: carry = 1'b0;
        endcase
    end

    assign zero = (w_alu_out == 32'h0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sync_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_sync_ram                                            |
// | Description : Directed self-checking bench for alu_sync_ram: RAM write/  |
// |               read, bus release, address wrap, ALU operations and a      |
// |               Fibonacci program run by a bench-side sequencer.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_sync_ram;

    localparam int c_DEPTH = 65536;

    logic        clk;
    logic        rst;
    logic [27:0] addr;
    wire  [31:0] data;
    logic        cs_input;
    logic        we;
    logic        oe;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_Sel;
    logic [31:0] ALU_Out;
`ifdef ALU_SYNC_RAM_FLAGS_EN
    logic        zero;
    logic        carry;
`endif

    logic [31:0] tb_data;
    logic        tb_drv;

    int checks;
    int failures;

    assign data = tb_drv ? tb_data : {32{1'bz}};

    alu_sync_ram #(
        .ADDR_WIDTH (28),
        .DATA_WIDTH (32),
        .DEPTH      (c_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data     (data),
        .cs_input (cs_input),
        .we       (we),
        .oe       (oe),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
`ifdef ALU_SYNC_RAM_FLAGS_EN
        .zero     (zero),
        .carry    (carry),
`endif
        .ALU_Out  (ALU_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write one word: present addr/data/we, let one rising edge capture it.
    task automatic mem_write(input logic [27:0] a, input logic [31:0] d);
        addr = a; tb_data = d; tb_drv = 1'b1;
        cs_input = 1'b1; we = 1'b1; oe = 1'b0;
        @(posedge clk); #1;
        tb_drv = 1'b0; cs_input = 1'b0; we = 1'b0;
    endtask

    // Read one word: set addr, sample the bus one edge later.
    task automatic mem_read(input logic [27:0] a, output logic [31:0] d);
        addr = a; tb_drv = 1'b0;
        cs_input = 1'b1; we = 1'b0; oe = 1'b1;
        @(posedge clk); #1;
        d = data;
        cs_input = 1'b0; oe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 28'h100; cs_input = 1'b1; oe = 1'b1; we = 1'b0;
        A = 32'd1; B = 32'd2; ALU_Sel = 4'b0000;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (!(data === {32{1'bz}} || data === 32'h0)) begin
            failures++; $display("FAIL reset_bus: data=%h required=released", data);
        end
        checks++;
        if (ALU_Out !== 32'd3) begin
            failures++; $display("FAIL reset_alu: ALU_Out=%h required=%h", ALU_Out, 32'd3);
        end
        rst = 1'b0; cs_input = 1'b0; oe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        mem_write(28'h100, 32'h1000010D);
        mem_write(28'h10E, 32'h0000000A);
        mem_read(28'h100, rd);
        checks++;
        if (rd !== 32'h1000010D) begin
            failures++; $display("FAIL read_100: got=%h required=%h", rd, 32'h1000010D);
        end
        mem_read(28'h10E, rd);
        checks++;
        if (rd !== 32'h0000000A) begin
            failures++; $display("FAIL read_10E: got=%h required=%h", rd, 32'h0000000A);
        end
        // Read right after overwrite returns the new word.
        mem_write(28'h10E, 32'hCAFE0001);
        mem_read(28'h10E, rd);
        checks++;
        if (rd !== 32'hCAFE0001) begin
            failures++; $display("FAIL raw_10E: got=%h required=%h", rd, 32'hCAFE0001);
        end
    endtask

    task automatic test_bus_release();
        logic [31:0] rd;
        tb_drv = 1'b0; addr = 28'h100;
        for (int k = 0; k < 3; k++) begin
            cs_input = (k != 0); oe = (k != 1); we = (k == 2);
            // we=1 here writes an undriven bus; follow with a restore write.
            #1;
            checks++;
            if (!(data === {32{1'bz}} || data === 32'h0)) begin
                failures++; $display("FAIL release_%0d: data=%h required=released", k, data);
            end
        end
        cs_input = 1'b0; oe = 1'b0; we = 1'b0;
        mem_write(28'h100, 32'h1000010D);
        // Write attempted during reset must be lost; bus released while reset.
        rst = 1'b1;
        mem_write(28'h100, 32'hDEADBEEF);
        cs_input = 1'b1; oe = 1'b1; #1;
        checks++;
        if (!(data === {32{1'bz}} || data === 32'h0)) begin
            failures++; $display("FAIL release_rst: data=%h required=released", data);
        end
        cs_input = 1'b0; oe = 1'b0;
        rst = 1'b0;
        mem_read(28'h100, rd);
        checks++;
        if (rd !== 32'h1000010D) begin
            failures++; $display("FAIL rst_write_blocked: got=%h required=%h", rd, 32'h1000010D);
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] rd;
        mem_write(28'd3, 32'h0);
        mem_write(28'(c_DEPTH + 3), 32'h55);
        mem_read(28'd3, rd);
        checks++;
        if (rd !== 32'h55) begin
            failures++; $display("FAIL addr_wrap: got=%h required=%h", rd, 32'h55);
        end
    endtask

    task automatic test_alu();
        logic [31:0] va [19];
        logic [31:0] vb [19];
        logic [3:0]  vs [19];
        logic [31:0] ve [19];
        va[0]=32'd5;        vb[0]=32'hFFFFFFFF; vs[0]=4'b0000; ve[0]=32'd4;
        va[1]=32'd2;        vb[1]=32'd3;        vs[1]=4'b0001; ve[1]=32'hFFFFFFFF;
        va[2]=32'h80000001; vb[2]=32'd0;        vs[2]=4'b0010; ve[2]=32'h00000002;
        va[3]=32'h80000001; vb[3]=32'd0;        vs[3]=4'b0011; ve[3]=32'h40000000;
        va[4]=32'h80000001; vb[4]=32'd0;        vs[4]=4'b0100; ve[4]=32'h00000003;
        va[5]=32'h80000001; vb[5]=32'd0;        vs[5]=4'b0101; ve[5]=32'hC0000000;
        va[6]=32'hF0F0;     vb[6]=32'hFF00;     vs[6]=4'b0110; ve[6]=32'hF000;
        va[7]=32'hF0F0;     vb[7]=32'hFF00;     vs[7]=4'b0111; ve[7]=32'h0FF0;
        va[8]=32'hF0F0;     vb[8]=32'hFF00;     vs[8]=4'b1000; ve[8]=32'hFFF0;
        va[9]=32'hF0F0;     vb[9]=32'hFF00;     vs[9]=4'b1001; ve[9]=32'hFFFF000F;
        va[10]=32'hF0F0;    vb[10]=32'hFF00;    vs[10]=4'b1010; ve[10]=32'hFFFF0FFF;
        va[11]=32'hF0F0;    vb[11]=32'hFF00;    vs[11]=4'b1011; ve[11]=32'hFFFFF00F;
        va[12]=32'd3;       vb[12]=32'd2;       vs[12]=4'b1100; ve[12]=32'd1;
        va[13]=32'd2;       vb[13]=32'd3;       vs[13]=4'b1100; ve[13]=32'd0;
        va[14]=32'hFFFFFFFF; vb[14]=32'd1;      vs[14]=4'b1100; ve[14]=32'd1;
        va[15]=32'd7;       vb[15]=32'd7;       vs[15]=4'b1101; ve[15]=32'd1;
        va[16]=32'd7;       vb[16]=32'd8;       vs[16]=4'b1101; ve[16]=32'd0;
        va[17]=32'h12345678; vb[17]=32'h9ABCDEF0; vs[17]=4'b1110; ve[17]=32'h12345678;
        va[18]=32'h12345678; vb[18]=32'h9ABCDEF0; vs[18]=4'b1111; ve[18]=32'h9ABCDEF0;
        for (int i = 0; i < 19; i++) begin
            A = va[i]; B = vb[i]; ALU_Sel = vs[i]; #1;
            checks++;
            if (ALU_Out !== ve[i]) begin
                failures++;
                $display("FAIL alu_%0d sel=%b: got=%h required=%h", i, vs[i], ALU_Out, ve[i]);
            end
        end
    endtask

`ifdef ALU_SYNC_RAM_FLAGS_EN
    task automatic test_flags();
        A = 32'hFFFFFFFF; B = 32'd1; ALU_Sel = 4'b0000; #1;
        checks++;
        if (ALU_Out !== 32'h0 || zero !== 1'b1 || carry !== 1'b1) begin
            failures++;
            $display("FAIL flags_add: out=%h zero=%b carry=%b required=0/1/1", ALU_Out, zero, carry);
        end
        A = 32'd1; B = 32'd2; ALU_Sel = 4'b0001; #1;
        checks++;
        if (carry !== 1'b1 || zero !== 1'b0) begin
            failures++; $display("FAIL flags_sub: zero=%b carry=%b required=0/1", zero, carry);
        end
        A = 32'h80000001; ALU_Sel = 4'b0010; #1;
        checks++;
        if (carry !== 1'b1) begin
            failures++; $display("FAIL flags_shl: carry=%b required=1", carry);
        end
        A = 32'h80000000; ALU_Sel = 4'b0011; #1;
        checks++;
        if (carry !== 1'b0) begin
            failures++; $display("FAIL flags_shr: carry=%b required=0", carry);
        end
    endtask
`endif

    // Bench-side sequencer: opcode in [31:28], operand address in [27:0].
    // 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 SKIP-if-AC-zero, 6 JUMP, 7 HALT.
    task automatic test_fibonacci();
        logic [31:0] prog [14];
        logic [31:0] ir;
        logic [31:0] ac;
        logic [31:0] opnd;
        logic [31:0] rd;
        logic [27:0] pc;
        logic        halted;
        logic        bad_op;
        prog[0]  = 32'h1000010D;  // AC = b
        prog[1]  = 32'h3000010C;  // AC = a + b
        prog[2]  = 32'h20000110;  // t = AC
        prog[3]  = 32'h1000010D;  // AC = b
        prog[4]  = 32'h2000010C;  // a = b
        prog[5]  = 32'h10000110;  // AC = t
        prog[6]  = 32'h2000010D;  // b = t
        prog[7]  = 32'h1000010E;  // AC = n
        prog[8]  = 32'h3000010F;  // AC = n + (-1)
        prog[9]  = 32'h2000010E;  // n = AC
        prog[10] = 32'h50000000;  // skip next if AC == 0
        prog[11] = 32'h60000000;  // jump 0
        prog[12] = 32'h1000010D;  // AC = b
        prog[13] = 32'h70000000;  // halt
        for (int i = 0; i < 14; i++) mem_write(28'(i), prog[i]);
        mem_write(28'h10C, 32'd0);
        mem_write(28'h10D, 32'd1);
        mem_write(28'h10E, 32'd10);
        mem_write(28'h10F, 32'hFFFFFFFF);
        pc = 28'd0; ac = 32'd0; halted = 1'b0; bad_op = 1'b0;
        for (int step = 0; step < 400 && !halted; step++) begin
            mem_read(pc, ir);
            case (ir[31:28])
                4'd1: begin mem_read(ir[27:0], ac); pc = pc + 28'd1; end
                4'd2: begin mem_write(ir[27:0], ac); pc = pc + 28'd1; end
                4'd3, 4'd4: begin
                    mem_read(ir[27:0], opnd);
                    A = ac; B = opnd; ALU_Sel = (ir[31:28] == 4'd3) ? 4'b0000 : 4'b0001;
                    #1; ac = ALU_Out; pc = pc + 28'd1;
                end
                4'd5: pc = pc + ((ac == 32'd0) ? 28'd2 : 28'd1);
                4'd6: pc = ir[27:0];
                4'd7: halted = 1'b1;
                default: begin halted = 1'b1; bad_op = 1'b1; end
            endcase
        end
        checks++;
        if (!halted || bad_op) begin
            failures++; $display("FAIL fib_halt: halted=%b bad_op=%b required=1/0", halted, bad_op);
        end
        checks++;
        if (ac !== 32'd89) begin
            failures++; $display("FAIL fib_ac: got=%0d required=89", ac);
        end
        mem_read(28'h10D, rd);
        checks++;
        if (rd !== 32'h59) begin
            failures++; $display("FAIL fib_mem: got=%h required=%h", rd, 32'h59);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        tb_drv = 1'b0; tb_data = 32'h0;
        rst = 1'b1; addr = 28'h0; cs_input = 1'b0; we = 1'b0; oe = 1'b0;
        A = 32'h0; B = 32'h0; ALU_Sel = 4'h0;
        test_reset();
        test_write_read();
        test_bus_release();
        test_addr_wrap();
        test_alu();
`ifdef ALU_SYNC_RAM_FLAGS_EN
        test_flags();
`endif
        test_fibonacci();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
